cp0_unit: RTL
=============

Name: cp0_unit

Overview:
- Coprocessor 0 for the P7 MIPS pipeline, attached at the M stage.
- Consumes the exception code, branch-delay flag and PC that the E/M pipeline register delivers to M.
- Holds SR, Cause, EPC and PRId, and arbitrates hardware interrupts against synchronous exceptions.
- Drives IntReq and EPC back to every pipeline register: IntReq flushes them and redirects fetch to 0x4180; EPC is the return target for eret.

Parameters:
- PRID_VALUE, 32'h2021_0007, read-only processor ID returned for CP0 register 15.
- HWINT_W, 6, number of hardware interrupt lines, mapped to IP/IM bits [15:10].

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- A1  input  5  mfc0 read register number.
- A2  input  5  mtc0 write register number.
- DIn  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable (M-stage mtc0).
- EXLClr  input  1  eret in M stage.
- PC_M  input  32  PC of the M-stage instruction.
- PC_Alt  input  32  PC of the next older live instruction; used when M holds a bubble.
- BD_M  input  1  M-stage instruction is in a branch delay slot.
- ExcCode_M  input  5 ([6:2])  exception code from the M-stage register; 0 means none.
- HWInt  input  HWINT_W ([7:2])  device interrupt lines, level-sensitive.
- IntReq  output  1  take interrupt or exception this cycle.
- EPC  output  32  eret target.
- DOut  output  32  mfc0 read data.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low.
- Register layout:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): constant.
- Reset (reset=0, immediate, no clock needed):
  - SR=0, Cause=0, EPC=0.
  - IntReq forced 0 while reset is low.
  - DOut and EPC outputs then reflect the zero registers.
- IntReq is combinational, with no added latency:
  - IntPend = |(HWInt & IM) & IE & !EXL.
  - ExcPend = (ExcCode_M != 0) & !EXL.
  - IntReq = IntPend | ExcPend.
  - When both are pending, the interrupt has priority.
- On a posedge with IntReq=1:
  - EXL <= 1.
  - Cause.BD <= BD_M.
  - Cause.ExcCode <= IntPend ? 0 : ExcCode_M.
  - EPC <= base - (BD_M ? 4 : 0), with base = (PC_M != 0) ? PC_M : PC_Alt.
  - The address is kept word-aligned: {[31:2], 2'b00}.
  - A concurrent mtc0 and a concurrent EXLClr are both discarded, because the instruction is flushed.
- Cause.IP <= HWInt on every posedge, independent of IM, IE and EXL.
- EXLClr=1 with IntReq=0: EXL <= 0 at the next posedge; IM, IE and EPC are unchanged.
- mtc0 (WE=1, IntReq=0):
  - A2=12 writes IM, EXL and IE only.
  - A2=14 writes EPC with DIn[31:2], 2'b00.
  - Writes to A2=13, 15 or any other number are ignored.
- mfc0: DOut = register selected by A1, combinational. It returns the pre-edge value; there is no write-to-read bypass. Unimplemented numbers read 0.
- EPC output bypass: when WE=1 and A2=14 in the same cycle, the EPC output equals the aligned DIn, so an eret immediately after mtc0 EPC returns correctly. Otherwise the EPC output equals the EPC register.
- Simultaneous mtc0 SR and eret (not architecturally legal): the mtc0 value is applied first, then EXL is cleared.
- Level interrupt held during the handler: no retrigger while EXL=1. It re-fires in the first cycle after EXL clears, provided IE=1.

Decomposition:
- Add to macro.v:
  - CP0 register numbers: `CP0_SR, `CP0_CAUSE, `CP0_EPC, `CP0_PRID.
  - SR/Cause bit positions.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - Handler vector 32'h4180.
- Single flat module; no sub-module is warranted.

Test Plan:
- Assert reset=0 mid-cycle with ExcCode_M=12 -> IntReq=0 at once, SR/Cause/EPC read 0, DOut for A1=15 equals PRID_VALUE.
- mtc0 SR=32'h0000_0401, HWInt=6'b000001, PC_M=32'h3010, BD_M=0 -> IntReq=1 same cycle; after the edge EPC=32'h3010, ExcCode=0, EXL=1, IntReq=0.
- ExcCode_M=12, BD_M=1, PC_M=32'h3024 with HWInt active and unmasked -> interrupt wins, ExcCode=0, BD=1, EPC=32'h3020.
- PC_M=0 (bubble), PC_Alt=32'h3040, ExcCode_M=4 -> EPC=32'h3040, Cause.ExcCode=4.
- In handler, mtc0 EPC=32'h3103 then eret the next cycle -> EPC output 32'h3100 in the mtc0 cycle; EXL=0 after the eret edge.
- HWInt held high through eret with IE=1 -> IntReq reasserts in the first cycle after EXL clears.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// Shared definitions for Coprocessor 0 of the P7 MIPS pipeline.
// Holds CP0 register numbers, SR/Cause bit positions, exception codes,
// the exception handler vector and a word-alignment helper.
package cp0_unit_pkg;

  // CP0 register numbers addressed by mfc0/mtc0
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR / Cause field positions
  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int IP_IM_LO     = 10;
  localparam int CAUSE_BD_BIT = 31;
  localparam int EXC_LO       = 2;

  // Exception codes carried down the pipeline
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Fetch redirect target whenever IntReq is taken
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

  // EPC is always kept on a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 attached at the M stage.
// Holds SR, Cause, EPC and PRId and arbitrates hardware interrupts against
// synchronous exceptions coming down the E/M pipeline register.
// Ports:
//   clk, reset (async, active-low)
//   A1        mfc0 read register number       -> DOut (combinational)
//   A2/DIn/WE mtc0 write register/data/enable
//   EXLClr    eret in M stage
//   PC_M, PC_Alt, BD_M, ExcCode_M  M-stage instruction context
//   HWInt     level-sensitive device interrupt lines
//   IntReq    flush pipeline and redirect fetch to the handler
//   EPC       eret return target (bypasses a same-cycle mtc0 EPC)
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2021_0007,
  parameter int          HWINT_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIn,
  input  logic               WE,
  input  logic               EXLClr,
  input  logic [31:0]        PC_M,
  input  logic [31:0]        PC_Alt,
  input  logic               BD_M,
  input  logic [6:2]         ExcCode_M,
  input  logic [HWINT_W+1:2] HWInt,
  output logic               IntReq,
  output logic [31:0]        EPC,
  output logic [31:0]        DOut
);

  logic [HWINT_W-1:0] sr_im;
  logic               sr_exl;
  logic               sr_ie;
  logic               cause_bd;
  logic [HWINT_W-1:0] cause_ip;
  logic [4:0]         cause_exc;
  logic [31:0]        epc_reg;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] trap_base;
  logic [31:0] trap_epc;
  logic [31:0] sr_value;
  logic [31:0] cause_value;
  logic        wr_sr;
  logic        wr_epc;

  // Interrupt/exception arbitration; held low while reset is asserted
  always_comb begin
    int_pend = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    exc_pend = (ExcCode_M != 5'd0) & ~sr_exl;
    IntReq   = reset & (int_pend | exc_pend);
  end

  // A bubble in M has PC 0, so the next older live instruction's PC is used;
  // a delay-slot instruction returns to its branch
  always_comb begin
    trap_base = (PC_M != 32'd0) ? PC_M : PC_Alt;
    trap_epc  = word_align(trap_base - (BD_M ? 32'd4 : 32'd0));
    wr_sr     = WE & (A2 == CP0_SR);
    wr_epc    = WE & (A2 == CP0_EPC);
  end

  // Architectural state; a taken trap discards the flushed mtc0/eret
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc_reg   <= 32'd0;
    end else begin
      cause_ip <= HWInt;
      if (IntReq) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BD_M;
        cause_exc <= int_pend ? EXC_INT : ExcCode_M;
        epc_reg   <= trap_epc;
      end else begin
        if (wr_sr) begin
          sr_im  <= DIn[IP_IM_LO +: HWINT_W];
          sr_exl <= DIn[SR_EXL_BIT];
          sr_ie  <= DIn[SR_IE_BIT];
        end
        if (wr_epc) begin
          epc_reg <= word_align(DIn);
        end
        // Ordered after the mtc0 SR write so an eret clears EXL last
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  // Readback views of SR and Cause with unimplemented bits forced to 0
  always_comb begin
    sr_value                            = 32'd0;
    sr_value[IP_IM_LO +: HWINT_W]       = sr_im;
    sr_value[SR_EXL_BIT]                = sr_exl;
    sr_value[SR_IE_BIT]                 = sr_ie;
    cause_value                         = 32'd0;
    cause_value[CAUSE_BD_BIT]           = cause_bd;
    cause_value[IP_IM_LO +: HWINT_W]    = cause_ip;
    cause_value[EXC_LO +: 5]            = cause_exc;
  end

  // mfc0 returns pre-edge register contents
  always_comb begin
    DOut = 32'd0;
    case (A1)
      CP0_SR:    DOut = sr_value;
      CP0_CAUSE: DOut = cause_value;
      CP0_EPC:   DOut = epc_reg;
      CP0_PRID:  DOut = PRID_VALUE;
      default:   DOut = 32'd0;
    endcase
  end

  // Forward a same-cycle mtc0 EPC so a following eret sees the new target
  always_comb begin
    EPC = wr_epc ? word_align(DIn) : epc_reg;
  end

endmodule
